// File: rtl/drlp_pkg.sv
// +---------------------------------------------------------------+
// | drlp_pkg : window-mode encodings and row-count helper           |
// | rev 1.0                                                         |
// +---------------------------------------------------------------+
`default_nettype none

package drlp_pkg;

   localparam int PIX_WIDTH = 8;
   localparam int ROW_CNT_W = 3;

   localparam logic [1:0] MODE_3X3 = 2'b00;
   localparam logic [1:0] MODE_4X4 = 2'b01;
   localparam logic [1:0] MODE_5X5 = 2'b10;
   localparam logic [1:0] MODE_6X6 = 2'b11;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } win_state_e;

   function automatic logic [ROW_CNT_W-1:0] rows_for_mode(input logic [1:0] mode);
      logic [ROW_CNT_W-1:0] rows;
      case (mode)
         MODE_3X3: rows = 3'd3;
         MODE_4X4: rows = 3'd4;
         MODE_5X5: rows = 3'd5;
         default:  rows = 3'd6;
      endcase
      return rows;
   endfunction

endpackage

`default_nettype wire

// File: rtl/drlp_row_fifo.sv
// +---------------------------------------------------------------+
// | drlp_row_fifo : synchronous row FIFO, push-when-full with pop   |
// | rev 1.0                                                         |
// +---------------------------------------------------------------+
`default_nettype none

module drlp_row_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a row when the same cycle frees a slot.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/drlp_win_assembler.sv
// +---------------------------------------------------------------+
// | drlp_win_assembler : stacks buffered row words into a KxK window|
// | rev 1.0                                                         |
// +---------------------------------------------------------------+
`default_nettype none

module drlp_win_assembler
   import drlp_pkg::*;
#(
   parameter int ROW_WIDTH  = 48,
   parameter int MAX_ROWS   = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [1:0]                    i_mode,
   input  logic [ROW_WIDTH-1:0]          i_row_data,
   input  logic                          i_row_valid,
   input  logic                          i_clear,
   output logic [ROW_WIDTH*MAX_ROWS-1:0] o_win_data,
   output logic                          o_win_valid,
   input  logic                          i_win_ack,
   output logic [1:0]                    o_win_mode,
   output logic                          o_fifo_afull,
   output logic                          o_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] AFULL_LVL = (AW+1)'(FIFO_DEPTH - 2);

   win_state_e             state;
   logic [ROW_CNT_W-1:0]   row_cnt;
   logic [ROW_WIDTH-1:0]   fifo_rdata;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [AW:0]            fifo_count;
   logic                   pop;
   logic [1:0]             eff_mode;
   logic                   last_row;

   assign pop          = (state == FILL) && !fifo_empty && !i_clear;
   // The first row of a window takes the live mode; later rows follow the latched one.
   assign eff_mode     = (row_cnt == '0) ? i_mode : o_win_mode;
   assign last_row     = (row_cnt == rows_for_mode(eff_mode) - 3'd1);
   assign o_fifo_afull = (fifo_count >= AFULL_LVL);

   drlp_row_fifo #(
      .WIDTH (ROW_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .clear (i_clear),
      .push  (i_row_valid),
      .pop   (pop),
      .wdata (i_row_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= FILL;
         row_cnt     <= '0;
         o_win_data  <= '0;
         o_win_valid <= 1'b0;
         o_win_mode  <= MODE_3X3;
         o_overflow  <= 1'b0;
      end else if (i_clear) begin
         state       <= FILL;
         row_cnt     <= '0;
         o_win_valid <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         if (i_row_valid && fifo_full && !pop) begin
            o_overflow <= 1'b1;
         end
         case (state)
            FILL: begin
               if (pop) begin
                  if (row_cnt == '0) begin
                     o_win_mode                <= i_mode;
                     o_win_data                <= '0;
                     o_win_data[ROW_WIDTH-1:0] <= fifo_rdata;
                  end else begin
                     o_win_data[row_cnt*ROW_WIDTH +: ROW_WIDTH] <= fifo_rdata;
                  end
                  if (last_row) begin
                     o_win_valid <= 1'b1;
                     row_cnt     <= '0;
                     state       <= HOLD;
                  end else begin
                     row_cnt <= row_cnt + 3'd1;
                  end
               end
            end
            HOLD: begin
               if (i_win_ack) begin
                  o_win_valid <= 1'b0;
                  state       <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_drlp_win_assembler.sv
// +---------------------------------------------------------------+
// | tb_drlp_win_assembler : directed bench for the window assembler |
// | rev 1.0                                                         |
// +---------------------------------------------------------------+
`default_nettype none

module tb_drlp_win_assembler;

   localparam int RW = 48;
   localparam int WW = RW * 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [RW-1:0] row_data = '0;
   logic          row_valid = 1'b0;
   logic          clear = 1'b0;
   logic [WW-1:0] win_data;
   logic          win_valid;
   logic          win_ack = 1'b0;
   logic [1:0]    win_mode;
   logic          fifo_afull;
   logic          overflow;

   int n_cmp = 0;
   int n_err = 0;
   logic [WW-1:0] exp_win;
   logic [WW-1:0] held_win;

   drlp_win_assembler dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mode      (mode),
      .i_row_data  (row_data),
      .i_row_valid (row_valid),
      .i_clear     (clear),
      .o_win_data  (win_data),
      .o_win_valid (win_valid),
      .i_win_ack   (win_ack),
      .o_win_mode  (win_mode),
      .o_fifo_afull(fifo_afull),
      .o_overflow  (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] pat(input logic [7:0] k);
      return {6{k}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_row(input logic [RW-1:0] d);
      row_data  = d;
      row_valid = 1'b1;
      tick();
      row_valid = 1'b0;
   endtask

   task automatic ack_window();
      win_ack = 1'b1;
      tick();
      win_ack = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #20;
      n_cmp++; if (win_data !== '0) begin n_err++; $display("FAIL rst_data got=%h exp=0", win_data); end
      n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", win_valid); end
      n_cmp++; if (win_mode !== 2'b00) begin n_err++; $display("FAIL rst_mode got=%b exp=00", win_mode); end
      n_cmp++; if (fifo_afull !== 1'b0) begin n_err++; $display("FAIL rst_afull got=%b exp=0", fifo_afull); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_mode4();
      mode = 2'b01;
      row_valid = 1'b1;
      row_data = 48'h11111111; tick();
      row_data = 48'h22222222; tick();
      row_data = 48'h33333333; tick();
      row_data = 48'h44444444; tick();
      row_valid = 1'b0;
      n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL m4_early_valid got=%b exp=0", win_valid); end
      tick();
      exp_win = '0;
      exp_win[0*RW +: RW] = 48'h11111111;
      exp_win[1*RW +: RW] = 48'h22222222;
      exp_win[2*RW +: RW] = 48'h33333333;
      exp_win[3*RW +: RW] = 48'h44444444;
      n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL m4_valid got=%b exp=1", win_valid); end
      n_cmp++; if (win_data !== exp_win) begin n_err++; $display("FAIL m4_data got=%h exp=%h", win_data, exp_win); end
      n_cmp++; if (win_mode !== 2'b01) begin n_err++; $display("FAIL m4_mode got=%b exp=01", win_mode); end
      ack_window();
      n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL m4_ack got=%b exp=0", win_valid); end
   endtask

   task automatic test_back_to_back();
      mode = 2'b10;
      for (int c = 1; c <= 12; c++) begin
         row_valid = (c <= 10);
         row_data  = pat(8'(8'h50 + c));
         win_ack   = (c == 7);
         tick();
         if (c == 5) begin
            n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL b2b_w1_early got=%b exp=0", win_valid); end
         end
         if (c == 6) begin
            exp_win = '0;
            for (int k = 0; k < 5; k++) exp_win[k*RW +: RW] = pat(8'(8'h51 + k));
            n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL b2b_w1_valid got=%b exp=1", win_valid); end
            n_cmp++; if (win_data !== exp_win) begin n_err++; $display("FAIL b2b_w1_data got=%h exp=%h", win_data, exp_win); end
         end
         if (c == 7) begin
            n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ack got=%b exp=0", win_valid); end
         end
         if (c == 11) begin
            n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL b2b_w2_early got=%b exp=0", win_valid); end
         end
      end
      row_valid = 1'b0;
      win_ack = 1'b0;
      exp_win = '0;
      for (int k = 0; k < 5; k++) exp_win[k*RW +: RW] = pat(8'(8'h56 + k));
      n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL b2b_w2_valid got=%b exp=1", win_valid); end
      n_cmp++; if (win_data !== exp_win) begin n_err++; $display("FAIL b2b_w2_data got=%h exp=%h", win_data, exp_win); end
      n_cmp++; if (win_mode !== 2'b10) begin n_err++; $display("FAIL b2b_mode got=%b exp=10", win_mode); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
      ack_window();
   endtask

   task automatic test_overflow();
      mode = 2'b11;
      for (int k = 0; k < 6; k++) push_row(pat(8'(8'h31 + k)));
      tick();
      exp_win = '0;
      for (int k = 0; k < 6; k++) exp_win[k*RW +: RW] = pat(8'(8'h31 + k));
      held_win = exp_win;
      n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL ovf_w1_valid got=%b exp=1", win_valid); end
      for (int k = 0; k < 6; k++) begin
         push_row(pat(8'(8'h41 + k)));
         if (k == 0) begin
            n_cmp++; if (fifo_afull !== 1'b0) begin n_err++; $display("FAIL ovf_afull_occ1 got=%b exp=0", fifo_afull); end
         end
         if (k == 1) begin
            n_cmp++; if (fifo_afull !== 1'b1) begin n_err++; $display("FAIL ovf_afull_occ2 got=%b exp=1", fifo_afull); end
         end
         if (k == 3) begin
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got=%b exp=0", overflow); end
         end
         if (k == 4) begin
            n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drop got=%b exp=1", overflow); end
         end
      end
      tick();
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      n_cmp++; if (win_data !== held_win) begin n_err++; $display("FAIL ovf_hold_data got=%h exp=%h", win_data, held_win); end
   endtask

   task automatic test_clear();
      row_data = pat(8'hEE);
      row_valid = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      row_valid = 1'b0;
      n_cmp++; if (fifo_afull !== 1'b0) begin n_err++; $display("FAIL clr_afull got=%b exp=0", fifo_afull); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
      n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got=%b exp=0", win_valid); end
      n_cmp++; if (win_data !== held_win) begin n_err++; $display("FAIL clr_data_kept got=%h exp=%h", win_data, held_win); end
      tick();
      n_cmp++; if (win_data !== held_win) begin n_err++; $display("FAIL clr_no_pop got=%h exp=%h", win_data, held_win); end
      mode = 2'b00;
      for (int k = 0; k < 3; k++) push_row(pat(8'(8'h81 + k)));
      tick();
      exp_win = '0;
      for (int k = 0; k < 3; k++) exp_win[k*RW +: RW] = pat(8'(8'h81 + k));
      n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL clr_fresh_valid got=%b exp=1", win_valid); end
      n_cmp++; if (win_data !== exp_win) begin n_err++; $display("FAIL clr_fresh_data got=%h exp=%h", win_data, exp_win); end
      n_cmp++; if (win_mode !== 2'b00) begin n_err++; $display("FAIL clr_fresh_mode got=%b exp=00", win_mode); end
      ack_window();
   endtask

   task automatic test_mode_switch();
      mode = 2'b00;
      row_valid = 1'b1;
      row_data = pat(8'h91); tick();
      row_data = pat(8'h92); tick();
      mode = 2'b11;
      row_data = pat(8'h93); tick();
      row_valid = 1'b0;
      tick();
      exp_win = '0;
      for (int k = 0; k < 3; k++) exp_win[k*RW +: RW] = pat(8'(8'h91 + k));
      n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL sw_valid got=%b exp=1", win_valid); end
      n_cmp++; if (win_mode !== 2'b00) begin n_err++; $display("FAIL sw_mode got=%b exp=00", win_mode); end
      n_cmp++; if (win_data !== exp_win) begin n_err++; $display("FAIL sw_data got=%h exp=%h", win_data, exp_win); end
      ack_window();
      for (int k = 0; k < 6; k++) push_row(pat(8'(8'hA1 + k)));
      n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL sw6_early got=%b exp=0", win_valid); end
      tick();
      exp_win = '0;
      for (int k = 0; k < 6; k++) exp_win[k*RW +: RW] = pat(8'(8'hA1 + k));
      n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL sw6_valid got=%b exp=1", win_valid); end
      n_cmp++; if (win_mode !== 2'b11) begin n_err++; $display("FAIL sw6_mode got=%b exp=11", win_mode); end
      n_cmp++; if (win_data !== exp_win) begin n_err++; $display("FAIL sw6_data got=%h exp=%h", win_data, exp_win); end
      ack_window();
   endtask

   task automatic test_reset_mid_window();
      mode = 2'b01;
      push_row(pat(8'h61));
      push_row(pat(8'h62));
      tick();
      rst = 1'b1;
      #2;
      n_cmp++; if (win_data !== '0) begin n_err++; $display("FAIL mrst_data got=%h exp=0", win_data); end
      n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got=%b exp=0", win_valid); end
      n_cmp++; if (win_mode !== 2'b00) begin n_err++; $display("FAIL mrst_mode got=%b exp=00", win_mode); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mrst_ovf got=%b exp=0", overflow); end
      #1 rst = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) push_row(pat(8'(8'h71 + k)));
      tick();
      exp_win = '0;
      for (int k = 0; k < 4; k++) exp_win[k*RW +: RW] = pat(8'(8'h71 + k));
      n_cmp++; if (win_valid !== 1'b1) begin n_err++; $display("FAIL mrst_win_valid got=%b exp=1", win_valid); end
      n_cmp++; if (win_data !== exp_win) begin n_err++; $display("FAIL mrst_win_data got=%h exp=%h", win_data, exp_win); end
      n_cmp++; if (win_mode !== 2'b01) begin n_err++; $display("FAIL mrst_win_mode got=%b exp=01", win_mode); end
      ack_window();
   endtask

   initial begin
      test_reset();
      test_mode4();
      test_back_to_back();
      test_overflow();
      test_clear();
      test_mode_switch();
      test_reset_mid_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
